// File: rtl/dma_periph_req_arb.sv
// dma_periph_req_arb
//   DMA-side responder for the peripheral request/clear handshake. Level
//   requests from up to 31 peripherals (TX and RX each) are arbitrated
//   round-robin. Each candidate uses index i = 2*(p-1)+dir, giving 62 entries.
//   One grant at a time is offered to the channel engine over valid/ready.
//   After the transfer completes, the serviced peripheral is acknowledged
//   through its clr bit. A one-cycle holdoff follows before the next search.
//
// Optional feature macro: DMA_PERIPH_TIMEOUT_EN
//   Adds a transfer watchdog and the timeout_err output.
//
// Ports
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-high reset
//   periph_tx_req  [31:1] level TX requests
//   periph_rx_req  [31:1] level RX requests
//   periph_tx_clr  [31:1] TX request clear, at most one bit high
//   periph_rx_clr  [31:1] RX request clear, at most one bit high
//   gnt_valid      grant offered to the channel engine
//   gnt_ready      channel engine accepts the grant
//   gnt_periph     granted peripheral 1..31, 0 when no grant
//   gnt_dir        0 = TX, 1 = RX
//   xfer_done      single-cycle pulse, granted transfer complete
//   busy           high in any state other than IDLE
//   timeout_err    (macro only) one-cycle pulse when the watchdog expires
module dma_periph_req_arb #(
    parameter int unsigned CLR_CYCLES     = 1,
    parameter logic [30:0] REQ_MASK       = 31'h7FFF_FFFF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:1] periph_tx_req,
    input  logic [31:1] periph_rx_req,
    output logic [31:1] periph_tx_clr,
    output logic [31:1] periph_rx_clr,
    output logic        gnt_valid,
    input  logic        gnt_ready,
    output logic [4:0]  gnt_periph,
    output logic        gnt_dir,
    input  logic        xfer_done,
    output logic        busy
`ifdef DMA_PERIPH_TIMEOUT_EN
    ,
    output logic        timeout_err
`endif
);

    localparam int NCAND = 62;

    typedef enum logic [2:0] {IDLE, ARB, GRANT, XFER, CLR, HOLDOFF} state_t;

    state_t      state, state_nxt;
    logic [61:0] elig;
    logic [5:0]  ptr;
    logic [5:0]  win_idx;
    logic        win_found;
    logic [6:0]  scan;
    logic [3:0]  clr_cnt;
    logic        clr_last;
    logic        xfer_end;

    // Build the interleaved candidate vector. Masked peripherals never become eligible.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default first.
        // A path that leaves it unassigned would infer a latch.
        elig = '0;
        for (int p = 1; p <= 31; p++) begin
            elig[2*(p-1)]     = periph_tx_req[p] & REQ_MASK[p-1];
            elig[2*(p-1) + 1] = periph_rx_req[p] & REQ_MASK[p-1];
        end
    end

    // Round-robin search. Start at ptr+1, wrap 61 -> 0, and keep the first hit.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 1; k <= NCAND; k++) begin
            scan = 7'(ptr) + 7'(k);
            if (scan >= 7'(NCAND)) scan = scan - 7'(NCAND);
            if (!win_found && elig[scan[5:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[5:0];
            end
        end
    end

    assign clr_last = (clr_cnt == 4'(CLR_CYCLES - 1));

`ifdef DMA_PERIPH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // The counter sits at zero outside XFER, so it is cleared on every entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_cnt <= '0;
        else       to_cnt <= (state == XFER) ? to_cnt + 1'b1 : '0;
    end

    assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    // A real completion in the expiry cycle wins, so no error is reported then.
    assign timeout_err = (state == XFER) && to_hit && !xfer_done;
    assign xfer_end    = xfer_done || to_hit;
`else
    assign xfer_end = xfer_done;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples values from before the edge and no ordering race can occur.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic. xfer_done only matters in XFER.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|elig)     state_nxt = ARB;
            ARB:     state_nxt = win_found ? GRANT : IDLE;
            GRANT:   if (gnt_ready) state_nxt = XFER;
            XFER:    if (xfer_end)  state_nxt = CLR;
            CLR:     if (clr_last)  state_nxt = HOLDOFF;
            HOLDOFF: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant registers, RR pointer and clr hold counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr        <= 6'd61;
            gnt_periph <= '0;
            gnt_dir    <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            clr_cnt <= (state == CLR) ? clr_cnt + 4'd1 : 4'd0;
            if (state == ARB && win_found) begin
                ptr        <= win_idx;
                gnt_periph <= win_idx[5:1] + 5'd1;
                gnt_dir    <= win_idx[0];
            end
            // The grant identity is cleared on entry to HOLDOFF.
            if (state == CLR && clr_last) begin
                gnt_periph <= '0;
                gnt_dir    <= 1'b0;
            end
        end
    end

    // Outputs decode from registered state only.
    // Reset therefore clears them at once, without waiting for a clock edge.
    always_comb begin
        periph_tx_clr = '0;
        periph_rx_clr = '0;
        if (state == CLR) begin
            if (gnt_dir) periph_rx_clr[gnt_periph] = 1'b1;
            else         periph_tx_clr[gnt_periph] = 1'b1;
        end
    end

    assign gnt_valid = (state == GRANT);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dma_periph_req_arb.sv
// Bench for dma_periph_req_arb.
// The main instance uses CLR_CYCLES=1 and TIMEOUT_CYCLES=16.
// The second instance uses CLR_CYCLES=3 and masks peripheral 30.
// Expected grants are queued when requests are raised.
// They are popped and compared when gnt_valid appears.
module tb_dma_periph_req_arb;

    typedef struct packed {
        logic [4:0] periph;
        logic       dir;
    } grant_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:1] tx_req, rx_req, tx_clr, rx_clr;
    logic        gnt_valid, gnt_ready, gnt_dir, xfer_done, busy;
    logic [4:0]  gnt_periph;

    logic [31:1] b_tx_req, b_rx_req, b_tx_clr, b_rx_clr;
    logic        b_valid, b_ready, b_dir, b_done, b_busy;
    logic [4:0]  b_periph;

`ifdef DMA_PERIPH_TIMEOUT_EN
    logic timeout_err, b_timeout_err;
`endif

    int     total = 0;
    int     bad   = 0;
    grant_t exp_q[$];
    grant_t cur;

    always #5 clk = ~clk;

    dma_periph_req_arb #(.CLR_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .periph_tx_req(tx_req), .periph_rx_req(rx_req),
        .periph_tx_clr(tx_clr), .periph_rx_clr(rx_clr),
        .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
        .gnt_periph(gnt_periph), .gnt_dir(gnt_dir),
        .xfer_done(xfer_done), .busy(busy)
`ifdef DMA_PERIPH_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    dma_periph_req_arb #(.CLR_CYCLES(3), .REQ_MASK(31'h5FFF_FFFF), .TIMEOUT_CYCLES(16)) dut3 (
        .clk(clk), .reset(reset),
        .periph_tx_req(b_tx_req), .periph_rx_req(b_rx_req),
        .periph_tx_clr(b_tx_clr), .periph_rx_clr(b_rx_clr),
        .gnt_valid(b_valid), .gnt_ready(b_ready),
        .gnt_periph(b_periph), .gnt_dir(b_dir),
        .xfer_done(b_done), .busy(b_busy)
`ifdef DMA_PERIPH_TIMEOUT_EN
        , .timeout_err(b_timeout_err)
`endif
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:1] onehot(input logic [4:0] p);
        onehot = 31'(1) << (p - 5'd1);
    endfunction

    // Wait for gnt_valid with a bounded budget.
    // Then pop the expected grant and compare it.
    task automatic await_grant();
        int n = 0;
        while (gnt_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", gnt_valid, 1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : grant_t'('0);
        check("grant_periph", gnt_periph, cur.periph);
        check("grant_dir", gnt_dir, cur.dir);
    endtask

    // Accept the grant, complete the transfer, and check the clr pulse.
    // The task returns at the IDLE cycle after HOLDOFF.
    task automatic finish_xfer(input bit drop);
        logic [31:1] etx, erx;
        gnt_ready = 1'b1;
        tick();
        check("xfer_valid_low", gnt_valid, 0);
        check("xfer_busy", busy, 1);
        check("xfer_no_clr", {tx_clr, rx_clr}, 0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        etx = cur.dir ? 31'(0) : onehot(cur.periph);
        erx = cur.dir ? onehot(cur.periph) : 31'(0);
        check("clr_tx", tx_clr, etx);
        check("clr_rx", rx_clr, erx);
        if (drop) begin
            if (cur.dir) rx_req[cur.periph] = 1'b0;
            else         tx_req[cur.periph] = 1'b0;
        end
        tick();
        check("holdoff_clr", {tx_clr, rx_clr}, 0);
        check("holdoff_periph", gnt_periph, 0);
        check("holdoff_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tx_req = '0; rx_req = '0; gnt_ready = 1'b0; xfer_done = 1'b0;
        b_tx_req = '0; b_rx_req = '0; b_ready = 1'b0; b_done = 1'b0;
        tick(); tick();
        check("rst_valid", gnt_valid, 0);
        check("rst_periph", gnt_periph, 0);
        check("rst_dir", gnt_dir, 0);
        check("rst_busy", busy, 0);
        check("rst_clr", {tx_clr, rx_clr}, 0);
        reset = 1'b0;
        tick();

        // Single TX request on peripheral 5 with two-cycle latency to gnt_valid
        exp_q.push_back(grant_t'{5'd5, 1'b0});
        tx_req[5] = 1'b1;
        gnt_ready = 1'b1;
        tick();
        check("lat_cycle1_valid", gnt_valid, 0);
        check("lat_cycle1_busy", busy, 1);
        tick();
        check("lat_cycle2_valid", gnt_valid, 1);
        await_grant();
        finish_xfer(1'b1);

        // Round-robin order (3,TX) (3,RX) (10,TX), then wrap back to (3,TX)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tx_req[3] = 1'b1; rx_req[3] = 1'b1; tx_req[10] = 1'b1;
        exp_q.push_back(grant_t'{5'd3, 1'b0});
        exp_q.push_back(grant_t'{5'd3, 1'b1});
        exp_q.push_back(grant_t'{5'd10, 1'b0});
        exp_q.push_back(grant_t'{5'd3, 1'b0});
        for (int g = 0; g < 4; g++) begin
            await_grant();
            finish_xfer(1'b0);
        end
        tx_req = '0; rx_req = '0;
        tick();

        // Committed grant: ready stays low, the request drops, and a stray xfer_done arrives
        gnt_ready = 1'b0;
        exp_q.push_back(grant_t'{5'd7, 1'b0});
        tx_req[7] = 1'b1;
        await_grant();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) tx_req[7] = 1'b0;
            if (i == 3) xfer_done = 1'b1;
            if (i == 4) xfer_done = 1'b0;
            check("hold_valid", gnt_valid, 1);
            check("hold_periph", gnt_periph, 7);
            tick();
        end
        finish_xfer(1'b0);

        // CLR_CYCLES=3 on RX 31. The masked TX 30 request is never granted.
        b_tx_req[30] = 1'b1;
        b_rx_req[31] = 1'b1;
        b_ready = 1'b1;
        for (int n = 0; n < 20 && b_valid !== 1'b1; n++) tick();
        check("b_grant_seen", b_valid, 1);
        check("b_grant_periph", b_periph, 31);
        check("b_grant_dir", b_dir, 1);
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        b_rx_req[31] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("b_rx_clr_on", b_rx_clr, onehot(5'd31));
            check("b_tx_clr_off", b_tx_clr, 0);
            tick();
        end
        check("b_holdoff_clr", {b_tx_clr, b_rx_clr}, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("b_masked_idle", b_busy, 0);
            tick();
        end

        // Reset during XFER for peripheral 12
        exp_q.push_back(grant_t'{5'd12, 1'b0});
        tx_req[12] = 1'b1;
        gnt_ready = 1'b1;
        await_grant();
        tick();
        check("p12_in_xfer", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_periph", gnt_periph, 0);
        check("async_rst_valid", gnt_valid, 0);
        check("async_rst_clr", {tx_clr, rx_clr}, 0);
        tx_req[12] = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("no_clr_after_abort", {tx_clr, rx_clr}, 0);
            tick();
        end
        // After reset, index 0 (1,TX) wins ahead of index 38 (20,TX).
        exp_q.push_back(grant_t'{5'd1, 1'b0});
        exp_q.push_back(grant_t'{5'd20, 1'b0});
        tx_req[1] = 1'b1; tx_req[20] = 1'b1;
        await_grant();
        finish_xfer(1'b1);
        await_grant();
        finish_xfer(1'b1);

`ifdef DMA_PERIPH_TIMEOUT_EN
        // Watchdog: no xfer_done, so timeout_err pulses in the 16th XFER cycle
        exp_q.push_back(grant_t'{5'd2, 1'b0});
        tx_req[2] = 1'b1;
        await_grant();
        tick();
        for (int k = 1; k <= 16; k++) begin
            check("timeout_err", timeout_err, (k == 16));
            if (k < 16) tick();
        end
        tick();
        check("timeout_clr", tx_clr, onehot(5'd2));
        check("timeout_err_low", timeout_err, 0);
        tx_req[2] = 1'b0;
        tick(); tick();
        check("timeout_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_periph_req_arb.md
Name: dma_periph_req_arb

Overview:
- DMA-side responder for the peripheral request/clear handshake.
- Accepts level requests `periph_tx_req[31:1]` and `periph_rx_req[31:1]` from up to 31 peripherals and round-robin arbitrates them.
- Presents one grant at a time to the channel engine via valid/ready, then waits for transfer completion.
- Acknowledges the serviced peripheral by driving its `periph_tx_clr` or `periph_rx_clr` bit.

Parameters:
- CLR_CYCLES, 1, number of cycles a clr bit is held high; legal range 1..15.
- REQ_MASK, 31'h7FFF_FFFF, per-peripheral enable; bit i-1 enables peripheral i. Masked requests are never granted.
- TIMEOUT_CYCLES, 1024, transfer watchdog limit; used only when DMA_PERIPH_TIMEOUT_EN is defined.

Ports:
- clk, in, 1, system clock; all logic on posedge.
- reset, in, 1, asynchronous active-high reset.
- periph_tx_req, in, [31:1], level TX requests from peripherals.
- periph_rx_req, in, [31:1], level RX requests from peripherals.
- periph_tx_clr, out, [31:1], TX request clear to peripherals; at most one bit high.
- periph_rx_clr, out, [31:1], RX request clear to peripherals; at most one bit high.
- gnt_valid, out, 1, grant offered to the channel engine.
- gnt_ready, in, 1, channel engine accepts the grant.
- gnt_periph, out, 5, granted peripheral number 1..31; 0 when no grant.
- gnt_dir, out, 1, 0 = TX, 1 = RX.
- xfer_done, in, 1, single-cycle pulse: granted transfer complete.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All clr bits, gnt_valid, gnt_periph, gnt_dir and busy are 0.
  - RR pointer is set to 61, so the first search starts at index 0.
- Candidate indexing: index i = 2*(p-1)+dir over 62 entries. Candidate i is eligible when its req bit AND the REQ_MASK bit for p are both 1.
- IDLE: when any candidate is eligible, go to ARB the next cycle.
- ARB (1 cycle):
  - Search eligible candidates from pointer+1 upward, wrapping 61 to 0, and take the first hit.
  - Register gnt_periph and gnt_dir, set pointer to the winning index, go to GRANT.
  - If no candidate is eligible (request dropped), return to IDLE.
- GRANT:
  - gnt_valid=1 and gnt_periph/gnt_dir stay stable until gnt_ready=1.
  - The grant is committed: if the request drops while waiting, gnt_valid still stays high.
  - When gnt_valid && gnt_ready, go to XFER on the next cycle and deassert gnt_valid.
- XFER: wait for xfer_done. A pulse on xfer_done in any other state is ignored.
- CLR:
  - Drive exactly one clr bit, selected by gnt_dir and gnt_periph, for CLR_CYCLES cycles using a 4-bit counter.
  - Then go to HOLDOFF.
- HOLDOFF (1 cycle):
  - Clr bits are 0 and gnt_periph is cleared to 0.
  - This cycle gives the peripheral time to drop its request, so a stale req is never re-granted. Then go to IDLE.
- Latency: minimum from a req seen in IDLE to gnt_valid is 2 cycles (IDLE→ARB→GRANT). Minimum from xfer_done to the clr bit asserting is 1 cycle.
- Fairness: after peripheral p is granted TX, a pending RX on the same p is the very next candidate.
- Simultaneous req and clr on the same bit: the clr stands; the request is re-evaluated only after HOLDOFF.
- A reset asserted mid-operation aborts the grant immediately; no clr is issued for the aborted transfer.

Optional Feature:
- Macro: DMA_PERIPH_TIMEOUT_EN.
- When defined:
  - Adds output port `timeout_err` (1 bit, reset value 0).
  - A counter runs in XFER. If xfer_done has not arrived after TIMEOUT_CYCLES cycles, `timeout_err` pulses high for 1 cycle and the state goes to CLR as if the transfer had completed.
  - The counter clears on entry to XFER.
- When not defined: no counter, no port, and XFER waits for xfer_done indefinitely.

Test Plan:
1. After reset, pulse `periph_tx_req[5]`=1 and hold gnt_ready=1 → gnt_valid at cycle +2 with gnt_periph=5 and gnt_dir=0; then xfer_done → `periph_tx_clr[5]` high for 1 cycle; busy returns to 0 after HOLDOFF.
2. tx_req[3], rx_req[3] and tx_req[10] all held high, each grant completed → grant order is (3,TX), (3,RX), (10,TX), then wraps back to (3,TX).
3. Hold gnt_ready=0 for 5 cycles with req[7] high, dropping req[7] at cycle 2 → gnt_valid stays high with periph=7; the grant is accepted at cycle 5 and the clr still occurs.
4. CLR_CYCLES=3 with rx_req[31] → `periph_rx_clr[31]` high for exactly 3 cycles, with all other clr bits 0 throughout.
5. Assert reset during XFER for periph 12 → all outputs 0 asynchronously; no clr[12] is issued; the next search starts at index 0.
6. With DMA_PERIPH_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, grant tx_req[2] and never send xfer_done → `timeout_err` pulses at the 16th XFER cycle, then `periph_tx_clr[2]` is driven.
